// File: rtl/wishbone_master_ctrl_if.sv
// Wishbone classic bus bundle between the single-transfer initiator and a responder.
// Ports (signals):
//   wbm_cyc_o  bus cycle               wbm_stb_o  strobe
//   wbm_we_o   write enable            wbm_sel_o  byte selects (DW/8)
//   wbm_adr_o  byte address (AW)       wbm_dat_o  write data (DW)
//   wbm_ack_i  responder acknowledge   wbm_dat_i  responder read data (DW)
// Modports: master (initiator side), slave (responder side).
interface wishbone_master_ctrl_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic              wbm_cyc_o;
  logic              wbm_stb_o;
  logic              wbm_we_o;
  logic [DW/8-1:0]   wbm_sel_o;
  logic [AW-1:0]     wbm_adr_o;
  logic [DW-1:0]     wbm_dat_o;
  logic              wbm_ack_i;
  logic [DW-1:0]     wbm_dat_i;

  modport master (
    output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    input  wbm_ack_i, wbm_dat_i
  );

  modport slave (
    input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
    output wbm_ack_i, wbm_dat_i
  );
endinterface

// File: rtl/wishbone_master_ctrl.sv
// Wishbone classic single-transfer initiator. Takes one read/write command
// through a valid/ready handshake, runs one cyc/stb bus cycle and returns
// the read data, or an error when no ack arrives within TIMEOUT bus cycles.
// Ports:
//   wb_clk_i, wb_rst_i       clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o  command handshake; cmd_we_i/adr/dat/sel payload
//   rsp_valid_o/rsp_ready_i  response handshake; rsp_dat_o, rsp_err_o payload
//   wbm                      Wishbone bus (master modport)
module wishbone_master_ctrl #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                        wb_clk_i,
  input  logic                        wb_rst_i,
  input  logic                        cmd_valid_i,
  output logic                        cmd_ready_o,
  input  logic                        cmd_we_i,
  input  logic [AW-1:0]               cmd_adr_i,
  input  logic [DW-1:0]               cmd_dat_i,
  input  logic [DW/8-1:0]             cmd_sel_i,
  output logic                        rsp_valid_o,
  input  logic                        rsp_ready_i,
  output logic [DW-1:0]               rsp_dat_o,
  output logic                        rsp_err_o,
  wishbone_master_ctrl_if.master      wbm
);

  localparam int SW = DW / 8;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_C = CW'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e          state_r, state_s;
  logic [CW-1:0]   cnt_r, cnt_s;
  logic            cyc_r, cyc_s;
  logic            stb_r, stb_s;
  logic            we_r, we_s;
  logic [SW-1:0]   sel_r, sel_s;
  logic [AW-1:0]   adr_r, adr_s;
  logic [DW-1:0]   dat_r, dat_s;
  logic            ready_r, ready_s;
  logic            rsp_valid_r, rsp_valid_s;
  logic [DW-1:0]   rsp_dat_r, rsp_dat_s;
  logic            rsp_err_r, rsp_err_s;
  logic [CW-1:0]   cnt_inc_s;

  assign cnt_inc_s = cnt_r + CW'(1'b1);

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    state_s     = state_r;
    cnt_s       = cnt_r;
    cyc_s       = cyc_r;
    stb_s       = stb_r;
    we_s        = we_r;
    sel_s       = sel_r;
    adr_s       = adr_r;
    dat_s       = dat_r;
    ready_s     = ready_r;
    rsp_valid_s = rsp_valid_r;
    rsp_dat_s   = rsp_dat_r;
    rsp_err_s   = rsp_err_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          we_s    = cmd_we_i;
          adr_s   = cmd_adr_i;
          dat_s   = cmd_dat_i;
          sel_s   = cmd_sel_i;
          cnt_s   = {CW{1'b0}};
          cyc_s   = 1'b1;
          stb_s   = 1'b1;
          ready_s = 1'b0;
          state_s = ST_BUS;
        end else begin
          ready_s = 1'b1;
        end
      end
      ST_BUS: begin
        cnt_s = cnt_inc_s;
        // Ack is checked first so it wins over a coinciding timeout.
        if (wbm.wbm_ack_i) begin
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b0;
          rsp_dat_s   = we_r ? {DW{1'b0}} : wbm.wbm_dat_i;
          state_s     = ST_RESP;
        end else if (cnt_inc_s == TMO_C) begin
          // This was the TIMEOUT-th strobe cycle without ack.
          cyc_s       = 1'b0;
          stb_s       = 1'b0;
          rsp_valid_s = 1'b1;
          rsp_err_s   = 1'b1;
          rsp_dat_s   = {DW{1'b0}};
          state_s     = ST_RESP;
        end else begin
          state_s = ST_BUS;
        end
      end
      ST_RESP: begin
        if (rsp_ready_i) begin
          rsp_valid_s = 1'b0;
          rsp_err_s   = 1'b0;
          rsp_dat_s   = {DW{1'b0}};
          ready_s     = 1'b1;
          state_s     = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        cyc_s       = 1'b0;
        stb_s       = 1'b0;
        rsp_valid_s = 1'b0;
        rsp_err_s   = 1'b0;
        rsp_dat_s   = {DW{1'b0}};
        ready_s     = 1'b1;
        state_s     = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_r     <= ST_IDLE;
      cnt_r       <= {CW{1'b0}};
      cyc_r       <= 1'b0;
      stb_r       <= 1'b0;
      we_r        <= 1'b0;
      sel_r       <= {SW{1'b0}};
      adr_r       <= {AW{1'b0}};
      dat_r       <= {DW{1'b0}};
      ready_r     <= 1'b1;
      rsp_valid_r <= 1'b0;
      rsp_dat_r   <= {DW{1'b0}};
      rsp_err_r   <= 1'b0;
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      cyc_r       <= cyc_s;
      stb_r       <= stb_s;
      we_r        <= we_s;
      sel_r       <= sel_s;
      adr_r       <= adr_s;
      dat_r       <= dat_s;
      ready_r     <= ready_s;
      rsp_valid_r <= rsp_valid_s;
      rsp_dat_r   <= rsp_dat_s;
      rsp_err_r   <= rsp_err_s;
    end
  end

  assign cmd_ready_o   = ready_r;
  assign rsp_valid_o   = rsp_valid_r;
  assign rsp_dat_o     = rsp_dat_r;
  assign rsp_err_o     = rsp_err_r;
  assign wbm.wbm_cyc_o = cyc_r;
  assign wbm.wbm_stb_o = stb_r;
  assign wbm.wbm_we_o  = we_r;
  assign wbm.wbm_sel_o = sel_r;
  assign wbm.wbm_adr_o = adr_r;
  assign wbm.wbm_dat_o = dat_r;

endmodule

// File: tb/tb_wishbone_master_ctrl.sv
// Directed testbench for wishbone_master_ctrl with a behavioural responder
// whose ack delay is set per test (-1 = never ack).
module tb_wishbone_master_ctrl;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_dat;

  wishbone_master_ctrl_if #(.AW(AW), .DW(DW)) bus ();

  wishbone_master_ctrl #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
    .wb_clk_i    (clk),
    .wb_rst_i    (rst),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .cmd_we_i    (cmd_we),
    .cmd_adr_i   (cmd_adr),
    .cmd_dat_i   (cmd_dat),
    .cmd_sel_i   (cmd_sel),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_dat_o   (rsp_dat),
    .rsp_err_o   (rsp_err),
    .wbm         (bus.master)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Responder: acks on strobe cycle number resp_wait (0-based), tracks strobe run length.
  int          resp_wait = 0;
  logic [31:0] resp_data = 32'h0;
  int          stb_run   = 0;
  int          last_len  = 0;

  always @(negedge clk) begin
    if (bus.wbm_cyc_o && bus.wbm_stb_o) begin
      if (resp_wait >= 0 && stb_run == resp_wait) begin
        bus.wbm_ack_i = 1'b1;
        bus.wbm_dat_i = resp_data;
      end else begin
        bus.wbm_ack_i = 1'b0;
        bus.wbm_dat_i = 32'hBAD0_BAD0;
      end
      stb_run = stb_run + 1;
    end else begin
      bus.wbm_ack_i = 1'b0;
      bus.wbm_dat_i = 32'hBAD0_BAD0;
      if (stb_run != 0) last_len = stb_run;
      stb_run = 0;
    end
  end

  int lat;
  int bad;

  // Called at a negedge while cmd_ready is high; returns at the negedge after the accept edge.
  task automatic issue(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel);
    cmd_we    = we;
    cmd_adr   = adr;
    cmd_dat   = dat;
    cmd_sel   = sel;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
  endtask

  task automatic wait_rsp();
    while (!rsp_valid && lat < 60) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_adr = 32'h0;
    cmd_dat = 32'h0; cmd_sel = 4'h0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_cyc", 64'(bus.wbm_cyc_o), 64'd0);
    chk("rst_stb", 64'(bus.wbm_stb_o), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_err", 64'(rsp_err), 64'd0);
    chk("rst_rsp_dat", 64'(rsp_dat), 64'd0);
    chk("rst_adr", 64'(bus.wbm_adr_o), 64'd0);

    // 1: write, immediate ack
    resp_wait = 0; resp_data = 32'hFFFF_FFFF;
    issue(1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF);
    chk("t1_cyc", 64'(bus.wbm_cyc_o), 64'd1);
    chk("t1_stb", 64'(bus.wbm_stb_o), 64'd1);
    chk("t1_we", 64'(bus.wbm_we_o), 64'd1);
    chk("t1_adr", 64'(bus.wbm_adr_o), 64'h3000_0000);
    chk("t1_dat_o", 64'(bus.wbm_dat_o), 64'hDEAD_BEEF);
    chk("t1_sel", 64'(bus.wbm_sel_o), 64'hF);
    chk("t1_busy", 64'(cmd_ready), 64'd0);
    wait_rsp();
    chk("t1_lat", 64'(lat), 64'd2);
    chk("t1_err", 64'(rsp_err), 64'd0);
    chk("t1_dat", 64'(rsp_dat), 64'd0);
    consume();
    chk("t1_stb_len", 64'(last_len), 64'd1);
    chk("t1_valid_drop", 64'(rsp_valid), 64'd0);
    chk("t1_ready_back", 64'(cmd_ready), 64'd1);

    // 2: read, three wait states
    resp_wait = 3; resp_data = 32'h1234_5678;
    issue(1'b0, 32'h3000_0004, 32'h0, 4'hF);
    chk("t2_we", 64'(bus.wbm_we_o), 64'd0);
    chk("t2_adr", 64'(bus.wbm_adr_o), 64'h3000_0004);
    wait_rsp();
    chk("t2_lat", 64'(lat), 64'd5);
    chk("t2_dat", 64'(rsp_dat), 64'h1234_5678);
    chk("t2_err", 64'(rsp_err), 64'd0);
    consume();
    @(negedge clk);
    chk("t2_stb_len", 64'(last_len), 64'd4);
    chk("t2_adr_hold", 64'(bus.wbm_adr_o), 64'h3000_0004);

    // 3: read, never acked -> timeout
    resp_wait = -1;
    issue(1'b0, 32'h3000_0008, 32'h0, 4'hF);
    wait_rsp();
    chk("t3_lat", 64'(lat), 64'd17);
    chk("t3_err", 64'(rsp_err), 64'd1);
    chk("t3_dat", 64'(rsp_dat), 64'd0);
    consume();
    chk("t3_stb_len", 64'(last_len), 64'd16);

    // 4: response back-pressure, second command waits for the handshake
    resp_wait = 0; resp_data = 32'hCAFE_F00D;
    issue(1'b0, 32'h3000_000C, 32'h0, 4'hF);
    wait_rsp();
    chk("t4_lat", 64'(lat), 64'd2);
    chk("t4_dat", 64'(rsp_dat), 64'hCAFE_F00D);
    cmd_we = 1'b1; cmd_adr = 32'h3000_0010; cmd_dat = 32'h1122_3344; cmd_sel = 4'h3;
    cmd_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!(rsp_valid && rsp_dat == 32'hCAFE_F00D && !rsp_err && !cmd_ready && !bus.wbm_stb_o))
        bad++;
    end
    chk("t4_hold_bad", 64'(bad), 64'd0);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("t4_valid_drop", 64'(rsp_valid), 64'd0);
    chk("t4_ready_back", 64'(cmd_ready), 64'd1);
    chk("t4_no_early_stb", 64'(bus.wbm_stb_o), 64'd0);
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 1;
    chk("t4_2nd_stb", 64'(bus.wbm_stb_o), 64'd1);
    chk("t4_2nd_adr", 64'(bus.wbm_adr_o), 64'h3000_0010);
    chk("t4_2nd_sel", 64'(bus.wbm_sel_o), 64'h3);
    wait_rsp();
    chk("t4_2nd_lat", 64'(lat), 64'd2);
    chk("t4_2nd_dat", 64'(rsp_dat), 64'd0);
    consume();

    // 5: reset while strobe is high
    resp_wait = -1;
    issue(1'b0, 32'h3000_0014, 32'h0, 4'hF);
    chk("t5_stb_before", 64'(bus.wbm_stb_o), 64'd1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("t5_cyc_rst", 64'(bus.wbm_cyc_o), 64'd0);
    chk("t5_stb_rst", 64'(bus.wbm_stb_o), 64'd0);
    chk("t5_valid_rst", 64'(rsp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rsp_valid || bus.wbm_stb_o || !cmd_ready) bad++;
    end
    chk("t5_quiet_after", 64'(bad), 64'd0);

    // 6: ack on the last allowed strobe cycle
    resp_wait = TIMEOUT - 1; resp_data = 32'hA5A5_A5A5;
    issue(1'b0, 32'h3000_0018, 32'h0, 4'hF);
    wait_rsp();
    chk("t6_lat", 64'(lat), 64'd17);
    chk("t6_err", 64'(rsp_err), 64'd0);
    chk("t6_dat", 64'(rsp_dat), 64'hA5A5_A5A5);
    consume();
    chk("t6_stb_len", 64'(last_len), 64'd16);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
